ervp_dma_axi_write_merger: RTL and testbench
============================================

ERVP_DMA_AXI_WRITE_MERGER -- requirements
Module: ervp_dma_axi_write_merger

Interface
- REQ-001 Parameter NUM_CH, default 4: number of DMA write channels merged (2..16).
- REQ-002 Parameter BW_ADDR, default 32: AXI address width.
- REQ-003 Parameter BW_AXI_DATA, default 32: AXI data width; strobe width BW_AXI_DATA/8.
- REQ-004 Parameter BW_AXI_TID, default 4: master ID width, SHALL satisfy NUM_CH <= 2**BW_AXI_TID.
- REQ-005 Parameter ORDER_DEPTH, default 4: W-order FIFO depth (power of 2, >=2).
- REQ-006 clk  in  1  single clock for all logic.
- REQ-007 rstnn  in  1  asynchronous active-low reset.
- REQ-008 s_aw{addr,len,size,burst}  in  NUM_CH*{BW_ADDR,8,3,2}  packed per-channel AW fields (AXI3 len is 4 bits, zero-extended).
- REQ-009 s_awvalid in / s_awready out  NUM_CH each  per-channel AW handshake.
- REQ-010 s_w{data,strb,last,valid}  in  NUM_CH*{BW_AXI_DATA,BW_AXI_DATA/8,1,1}; s_wready  out  NUM_CH.
- REQ-011 s_bresp  out  NUM_CH*2; s_bvalid  out  NUM_CH; s_bready  in  NUM_CH.
- REQ-012 m_aw{id,addr,len,size,burst,valid}  out  {BW_AXI_TID,BW_ADDR,8,3,2,1}; m_awready  in  1.
- REQ-013 m_w{id,data,strb,last,valid}  out  {BW_AXI_TID,BW_AXI_DATA,BW_AXI_DATA/8,1,1}; m_wready  in  1.
- REQ-014 m_b{id,resp,valid}  in  {BW_AXI_TID,2,1}; m_bready  out  1.
- REQ-015 busy  out  1  high while AW issue pending or W-order FIFO non-empty.
- REQ-016 bid_err  out  1  one-cycle pulse on B handshake with m_bid >= NUM_CH.

Function
- REQ-017 AW FSM states IDLE, ISSUE; IDLE->ISSUE when any s_awvalid and W-order FIFO not full; ISSUE->IDLE on m_awvalid&&m_awready.
- REQ-018 In IDLE, winner = first asserted s_awvalid at index (last_grant+1) mod NUM_CH upward, wrapping; s_awready[winner] high that cycle only, fields registered.
- REQ-019 In ISSUE m_awvalid=1, m_aw* from register, m_awid = winner index zero-extended; all s_awready low.
- REQ-020 AW acceptance latency: one AW per 2 cycles minimum; last_grant updates at IDLE grant.
- REQ-021 On m_aw handshake winner index pushed into W-order FIFO.
- REQ-022 W path: FIFO head selects channel; m_w* = s_w*[head], m_wid = head, m_wvalid = s_wvalid[head] && !empty, s_wready[head] = m_wready && !empty, other s_wready 0; combinational, zero latency.
- REQ-023 FIFO pops on m_wvalid&&m_wready&&m_wlast; push and pop in same cycle SHALL both take effect, count unchanged.
- REQ-024 FIFO full blocks new grants (s_awready all 0); W data never forwarded for a channel whose AW has not been handshaken on master.
- REQ-025 B path: m_bid < NUM_CH -> s_bvalid[m_bid]=m_bvalid, s_bresp[m_bid]=m_bresp, m_bready=s_bready[m_bid]; others s_bvalid 0.
- REQ-026 m_bid >= NUM_CH -> m_bready=1, response dropped, bid_err pulse.

Reset
- REQ-027 Async assert: FSM IDLE, FIFO empty, last_grant = NUM_CH-1, m_awvalid, s_awready, busy, bid_err = 0; registered AW fields 0.
- REQ-028 Reset mid-burst discards FIFO contents; after release first grant goes to lowest requesting index.

Verification
- REQ-029 Ch0,ch2 awvalid same cycle after reset -> ch0 granted (m_awid=0), then ch2 (m_awid=2).
- REQ-030 All 4 channels continuously requesting -> grant order 0,1,2,3,0; no channel starved.
- REQ-031 4 AWs accepted, m_wready=0 -> FIFO full, s_awready stays 0 until first wlast handshake, then next grant.
- REQ-032 Ch1 AW len=3, ch3 len=0 -> m_w shows 4 beats m_wid=1 then 1 beat m_wid=3; s_wready[3] low during ch1 beats.
- REQ-033 m_bvalid with m_bid=2, s_bready[2]=0 then 1 -> s_bvalid[2] held, m_bready follows; m_bid=7 (NUM_CH=4) -> m_bready=1, bid_err pulse.
- REQ-034 rstnn low during ISSUE with 2 FIFO entries -> m_awvalid=0, busy=0 immediately, m_wvalid=0.

Source files
------------

// File: rtl/ervp_dma_axi_write_merger.sv
// rtl/ervp_dma_axi_write_merger.sv - merges NUM_CH DMA AXI write masters onto one AXI write port
// Round-robin AW issue; an order FIFO of issued channel indices steers W beats, B routes by ID.
module ervp_dma_axi_write_merger #(
  parameter int NUM_CH      = 4,
  parameter int BW_ADDR     = 32,
  parameter int BW_AXI_DATA = 32,
  parameter int BW_AXI_TID  = 4,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rstnn,
  input  logic [NUM_CH*BW_ADDR-1:0]         s_awaddr,
  input  logic [NUM_CH*8-1:0]               s_awlen,
  input  logic [NUM_CH*3-1:0]               s_awsize,
  input  logic [NUM_CH*2-1:0]               s_awburst,
  input  logic [NUM_CH-1:0]                 s_awvalid,
  output logic [NUM_CH-1:0]                 s_awready,
  input  logic [NUM_CH*BW_AXI_DATA-1:0]     s_wdata,
  input  logic [NUM_CH*(BW_AXI_DATA/8)-1:0] s_wstrb,
  input  logic [NUM_CH-1:0]                 s_wlast,
  input  logic [NUM_CH-1:0]                 s_wvalid,
  output logic [NUM_CH-1:0]                 s_wready,
  output logic [NUM_CH*2-1:0]               s_bresp,
  output logic [NUM_CH-1:0]                 s_bvalid,
  input  logic [NUM_CH-1:0]                 s_bready,
  output logic [BW_AXI_TID-1:0]             m_awid,
  output logic [BW_ADDR-1:0]                m_awaddr,
  output logic [7:0]                        m_awlen,
  output logic [2:0]                        m_awsize,
  output logic [1:0]                        m_awburst,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  output logic [BW_AXI_TID-1:0]             m_wid,
  output logic [BW_AXI_DATA-1:0]            m_wdata,
  output logic [BW_AXI_DATA/8-1:0]          m_wstrb,
  output logic                              m_wlast,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  input  logic [BW_AXI_TID-1:0]             m_bid,
  input  logic [1:0]                        m_bresp,
  input  logic                              m_bvalid,
  output logic                              m_bready,
  output logic                              busy,
  output logic                              bid_err
);

  localparam int BW_STRB = BW_AXI_DATA / 8;
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int PTR_W   = $clog2(ORDER_DEPTH);

  typedef enum logic {ST_IDLE, ST_ISSUE} aw_state_e;

  aw_state_e           state_q, state_d;
  logic [CH_W-1:0]     last_grant_q;
  logic [CH_W-1:0]     aw_id_q;
  logic [BW_ADDR-1:0]  aw_addr_q;
  logic [7:0]          aw_len_q;
  logic [2:0]          aw_size_q;
  logic [1:0]          aw_burst_q;

  logic [CH_W-1:0]     fifo_q [ORDER_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;
  logic                fifo_full, fifo_empty, push, pop;
  logic [CH_W-1:0]     head;

  logic [BW_ADDR-1:0]     aw_addr_a  [NUM_CH];
  logic [7:0]             aw_len_a   [NUM_CH];
  logic [2:0]             aw_size_a  [NUM_CH];
  logic [1:0]             aw_burst_a [NUM_CH];
  logic [BW_AXI_DATA-1:0] w_data_a   [NUM_CH];
  logic [BW_STRB-1:0]     w_strb_a   [NUM_CH];

  logic                win_found, grant;
  logic [CH_W-1:0]     win_idx, cand_idx;
  int                  cand;
  logic                bid_ok;
  logic [CH_W-1:0]     bch;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign aw_addr_a[g]  = s_awaddr[g*BW_ADDR +: BW_ADDR];
    assign aw_len_a[g]   = s_awlen[g*8 +: 8];
    assign aw_size_a[g]  = s_awsize[g*3 +: 3];
    assign aw_burst_a[g] = s_awburst[g*2 +: 2];
    assign w_data_a[g]   = s_wdata[g*BW_AXI_DATA +: BW_AXI_DATA];
    assign w_strb_a[g]   = s_wstrb[g*BW_STRB +: BW_STRB];
  end

  // Search starts one past the last winner so every requester is reached within NUM_CH grants.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand     = (int'(last_grant_q) + i) % NUM_CH;
      cand_idx = CH_W'(cand);
      if (!win_found && s_awvalid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    s_awready = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found && !fifo_full) begin
          grant              = 1'b1;
          s_awready[win_idx] = 1'b1;
          state_d            = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_awready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_awvalid = (state_q == ST_ISSUE);
  assign m_awid    = BW_AXI_TID'(aw_id_q);
  assign m_awaddr  = aw_addr_q;
  assign m_awlen   = aw_len_q;
  assign m_awsize  = aw_size_q;
  assign m_awburst = aw_burst_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PTR_W+1)'(ORDER_DEPTH));
  assign head       = fifo_q[rd_ptr_q];
  assign push       = m_awvalid && m_awready;
  assign pop        = m_wvalid && m_wready && m_wlast;
  assign busy       = (state_q == ST_ISSUE) || !fifo_empty;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      aw_id_q      <= '0;
      aw_addr_q    <= '0;
      aw_len_q     <= '0;
      aw_size_q    <= '0;
      aw_burst_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_grant_q <= win_idx;
        aw_id_q      <= win_idx;
        aw_addr_q    <= aw_addr_a[win_idx];
        aw_len_q     <= aw_len_a[win_idx];
        aw_size_q    <= aw_size_a[win_idx];
        aw_burst_q   <= aw_burst_a[win_idx];
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= aw_id_q;
  end

  // W is steered purely by the FIFO head, so beats of a channel whose AW has not left stay blocked.
  always_comb begin
    s_wready = '0;
    if (!fifo_empty) s_wready[head] = m_wready;
  end

  assign m_wid    = BW_AXI_TID'(head);
  assign m_wdata  = w_data_a[head];
  assign m_wstrb  = w_strb_a[head];
  assign m_wlast  = s_wlast[head];
  assign m_wvalid = s_wvalid[head] && !fifo_empty;

  always_comb begin
    bid_ok   = (32'(m_bid) < 32'(NUM_CH));
    bch      = CH_W'(m_bid);
    s_bvalid = '0;
    s_bresp  = {NUM_CH{m_bresp}};
    m_bready = 1'b1;
    bid_err  = 1'b0;
    if (bid_ok) begin
      s_bvalid[bch] = m_bvalid;
      m_bready      = s_bready[bch];
    end else begin
      bid_err = m_bvalid;
    end
  end

endmodule

// File: tb/tb_ervp_dma_axi_write_merger.sv
// tb/tb_ervp_dma_axi_write_merger.sv - randomized self-checking bench for ervp_dma_axi_write_merger
// Reference model: round-robin rule, queue of expected AW issues and queue of W burst order.
module tb_ervp_dma_axi_write_merger;

  logic         clk = 1'b0;
  logic         rstnn;
  logic [127:0] s_awaddr;
  logic [31:0]  s_awlen;
  logic [11:0]  s_awsize;
  logic [7:0]   s_awburst;
  logic [3:0]   s_awvalid, s_awready;
  logic [127:0] s_wdata;
  logic [15:0]  s_wstrb;
  logic [3:0]   s_wlast, s_wvalid, s_wready;
  logic [7:0]   s_bresp;
  logic [3:0]   s_bvalid, s_bready;
  logic [3:0]   m_awid;
  logic [31:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid, m_awready;
  logic [3:0]   m_wid;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_wlast, m_wvalid, m_wready;
  logic [3:0]   m_bid;
  logic [1:0]   m_bresp;
  logic         m_bvalid, m_bready;
  logic         busy, bid_err;

  ervp_dma_axi_write_merger dut (
    .clk(clk), .rstnn(rstnn),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .bid_err(bid_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ch_addr [4];
  logic [7:0]  ch_len  [4];
  logic [2:0]  ch_size [4];
  logic [1:0]  ch_burst[4];
  logic [31:0] w_data  [4];
  logic [3:0]  w_strb  [4];
  int          wbeat   [4];
  int          chq     [4][$];
  aw_exp_t     pend[$];

  function automatic int rr_pick(input logic [3:0] mask, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (mask[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  function automatic aw_exp_t snap(input int ch);
    aw_exp_t e;
    e.ch = ch; e.addr = ch_addr[ch]; e.len = ch_len[ch];
    e.size = ch_size[ch]; e.burst = ch_burst[ch];
    return e;
  endfunction

  task automatic set_fields(input int ch, input int len);
    ch_addr[ch]  = $urandom;
    ch_len[ch]   = 8'(len);
    ch_size[ch]  = 3'($urandom_range(0, 2));
    ch_burst[ch] = 2'($urandom_range(0, 2));
    s_awaddr[ch*32 +: 32] = ch_addr[ch];
    s_awlen[ch*8 +: 8]    = ch_len[ch];
    s_awsize[ch*3 +: 3]   = ch_size[ch];
    s_awburst[ch*2 +: 2]  = ch_burst[ch];
  endtask

  task automatic new_wdata(input int ch);
    w_data[ch] = $urandom;
    w_strb[ch] = 4'($urandom);
    s_wdata[ch*32 +: 32] = w_data[ch];
    s_wstrb[ch*4 +: 4]   = w_strb[ch];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstnn = 1'b0;
    s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    pend.delete();
    for (int c = 0; c < 4; c++) begin
      chq[c].delete();
      wbeat[c] = 0;
      new_wdata(c);
    end
    repeat (2) @(negedge clk);
    rstnn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstnn = 1'b0;
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || s_awready !== 4'b0 || busy !== 1'b0 || bid_err !== 1'b0 ||
        m_wvalid !== 1'b0 || s_wready !== 4'b0 || s_bvalid !== 4'b0) begin
      errors++;
      $display("FAIL reset_state got awv=%b awr=%b busy=%b err=%b wv=%b wr=%b bv=%b exp all zero",
               m_awvalid, s_awready, busy, bid_err, m_wvalid, s_wready, s_bvalid);
    end
    do_reset();
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || busy !== 1'b0 || m_awaddr !== 32'h0 || m_awlen !== 8'h0) begin
      errors++;
      $display("FAIL reset_release got awv=%b busy=%b addr=%h len=%h exp 0", m_awvalid, busy, m_awaddr, m_awlen);
    end
  endtask

  task automatic test_priority();
    int ngrant = 0, nissue = 0, cyc = 0, exp_ch;
    logic [3:0] clr = '0;
    do_reset();
    set_fields(0, $urandom_range(0, 15));
    set_fields(2, $urandom_range(0, 15));
    s_awvalid = 4'b0101;
    m_awready = 1'b1;
    while (nissue < 2 && cyc < 40) begin
      #1;
      if (s_awready !== 4'b0) begin
        exp_ch = (ngrant == 0) ? 0 : 2;
        checks++;
        if (s_awready !== 4'(1 << exp_ch)) begin
          errors++;
          $display("FAIL priority_grant got=%b exp=%b", s_awready, 4'(1 << exp_ch));
        end
        ngrant++;
        clr = s_awready;
      end
      if (m_awvalid && m_awready) begin
        exp_ch = (nissue == 0) ? 0 : 2;
        checks++;
        if (m_awid !== 4'(exp_ch) || m_awaddr !== ch_addr[exp_ch] || m_awlen !== ch_len[exp_ch] ||
            m_awsize !== ch_size[exp_ch] || m_awburst !== ch_burst[exp_ch]) begin
          errors++;
          $display("FAIL priority_issue got id=%0d addr=%h len=%0d exp id=%0d addr=%h len=%0d",
                   m_awid, m_awaddr, m_awlen, exp_ch, ch_addr[exp_ch], ch_len[exp_ch]);
        end
        nissue++;
      end
      @(negedge clk);
      s_awvalid = s_awvalid & ~clr;
      clr = '0;
      cyc++;
    end
    checks++;
    if (nissue != 2) begin
      errors++;
      $display("FAIL priority_timeout got=%0d issues exp=2", nissue);
    end
  endtask

  task automatic test_round_robin();
    int lastg = 3, ngrant = 0, nissue = 0, cyc = 0, exp_ch;
    logic [3:0] clr = '0;
    aw_exp_t e;
    do_reset();
    for (int c = 0; c < 4; c++) set_fields(c, $urandom_range(0, 15));
    s_wvalid = 4'hF; s_wlast = 4'hF; m_wready = 1'b1;
    s_awvalid = 4'hF; m_awready = 1'b1;
    while (nissue < 20 && cyc < 400) begin
      #1;
      if (s_awready !== 4'b0) begin
        exp_ch = rr_pick(s_awvalid, lastg);
        checks++;
        if (s_awready !== 4'(1 << exp_ch)) begin
          errors++;
          $display("FAIL rr_grant #%0d got=%b exp=%b req=%b", ngrant, s_awready, 4'(1 << exp_ch), s_awvalid);
        end
        pend.push_back(snap(exp_ch));
        lastg = exp_ch;
        ngrant++;
        clr = s_awready;
      end
      if (m_awvalid && m_awready) begin
        checks++;
        if (pend.size() == 0) begin
          errors++;
          $display("FAIL rr_issue got unexpected id=%0d exp none", m_awid);
        end else begin
          e = pend.pop_front();
          if (m_awid !== 4'(e.ch) || m_awaddr !== e.addr || m_awlen !== e.len ||
              m_awsize !== e.size || m_awburst !== e.burst) begin
            errors++;
            $display("FAIL rr_issue got id=%0d addr=%h len=%0d exp id=%0d addr=%h len=%0d",
                     m_awid, m_awaddr, m_awlen, e.ch, e.addr, e.len);
          end
        end
        nissue++;
      end
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (clr[c]) set_fields(c, $urandom_range(0, 15));
      if (ngrant < 8) s_awvalid = 4'hF;
      else            s_awvalid = (s_awvalid & ~clr) | 4'($urandom & $urandom);
      clr = '0;
      m_awready = ($urandom_range(0, 1) == 1);
      cyc++;
    end
    checks++;
    if (nissue < 20) begin
      errors++;
      $display("FAIL rr_timeout got=%0d issues exp=20", nissue);
    end
  endtask

  task automatic test_w_order();
    int lastg = 3, cyc = 0, nburst = 0, nreq = 2, beats = 0, exp_ch, h, len;
    logic [3:0] clr = '0, wacc = '0;
    aw_exp_t e;
    int ord[$];
    int ordlen[$];
    do_reset();
    set_fields(1, 3); chq[1].push_back(3);
    set_fields(3, 0); chq[3].push_back(0);
    s_awvalid = 4'b1010; m_awready = 1'b1; m_wready = 1'b1;
    s_wvalid = 4'b1010; s_wlast = 4'b1000;
    while (nburst < 16 && cyc < 3000) begin
      #1;
      if (s_awready !== 4'b0) begin
        exp_ch = rr_pick(s_awvalid, lastg);
        checks++;
        if (s_awready !== 4'(1 << exp_ch)) begin
          errors++;
          $display("FAIL worder_grant got=%b exp=%b", s_awready, 4'(1 << exp_ch));
        end
        pend.push_back(snap(exp_ch));
        lastg = exp_ch;
        clr = s_awready;
      end
      checks++;
      if (ord.size() == 0) begin
        if (m_wvalid !== 1'b0 || s_wready !== 4'b0) begin
          errors++;
          $display("FAIL w_blocked got wvalid=%b wready=%b exp 0/0000", m_wvalid, s_wready);
        end
      end else begin
        h = ord[0];
        if (m_wvalid !== s_wvalid[h] || m_wid !== 4'(h) || m_wdata !== w_data[h] ||
            m_wstrb !== w_strb[h] || m_wlast !== s_wlast[h] || s_wready !== (4'(m_wready) << h)) begin
          errors++;
          $display("FAIL w_route got v=%b id=%0d d=%h l=%b rdy=%b exp v=%b id=%0d d=%h l=%b rdy=%b",
                   m_wvalid, m_wid, m_wdata, m_wlast, s_wready,
                   s_wvalid[h], h, w_data[h], s_wlast[h], 4'(m_wready) << h);
        end
        if (m_wvalid && m_wready) begin
          beats++;
          if (m_wlast) begin
            checks++;
            if (beats != ordlen[0] + 1) begin
              errors++;
              $display("FAIL w_burst_len ch=%0d got=%0d beats exp=%0d", h, beats, ordlen[0] + 1);
            end
            void'(ord.pop_front());
            void'(ordlen.pop_front());
            beats = 0;
            nburst++;
          end
        end
      end
      wacc = s_wready & s_wvalid;
      if (m_awvalid && m_awready) begin
        checks++;
        if (pend.size() == 0) begin
          errors++;
          $display("FAIL worder_issue got unexpected id=%0d exp none", m_awid);
        end else begin
          e = pend.pop_front();
          if (m_awid !== 4'(e.ch) || m_awaddr !== e.addr || m_awlen !== e.len) begin
            errors++;
            $display("FAIL worder_issue got id=%0d addr=%h len=%0d exp id=%0d addr=%h len=%0d",
                     m_awid, m_awaddr, m_awlen, e.ch, e.addr, e.len);
          end
          ord.push_back(e.ch);
          ordlen.push_back(int'(e.len));
        end
      end
      @(negedge clk);
      s_awvalid = s_awvalid & ~clr;
      for (int c = 0; c < 4; c++) begin
        if (wacc[c]) begin
          if (wbeat[c] == chq[c][0]) begin
            void'(chq[c].pop_front());
            wbeat[c] = 0;
          end else begin
            wbeat[c]++;
          end
          new_wdata(c);
        end
        if (cyc > 20 && !s_awvalid[c] && chq[c].size() < 2 && nreq < 16 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(0, 7);
          set_fields(c, len);
          chq[c].push_back(len);
          s_awvalid[c] = 1'b1;
          nreq++;
        end
        s_wvalid[c] = (chq[c].size() > 0) && ((s_wvalid[c] && !wacc[c]) || $urandom_range(0, 3) != 0);
        s_wlast[c]  = (chq[c].size() > 0) && (wbeat[c] == chq[c][0]);
      end
      clr = '0;
      m_awready = ($urandom_range(0, 3) != 0);
      m_wready  = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    checks++;
    if (nburst < 16) begin
      errors++;
      $display("FAIL worder_timeout got=%0d bursts exp=16", nburst);
    end
  endtask

  task automatic test_fifo_full();
    int nissue = 0, cyc = 0;
    logic [3:0] clr = '0;
    do_reset();
    for (int c = 0; c < 4; c++) set_fields(c, 0);
    s_wvalid = 4'hF; s_wlast = 4'hF; m_wready = 1'b0;
    s_awvalid = 4'hF; m_awready = 1'b1;
    while (nissue < 4 && cyc < 60) begin
      #1;
      if (s_awready !== 4'b0) clr = s_awready;
      if (m_awvalid && m_awready) nissue++;
      @(negedge clk);
      s_awvalid = s_awvalid & ~clr;
      clr = '0;
      cyc++;
    end
    checks++;
    if (nissue != 4) begin
      errors++;
      $display("FAIL full_fill got=%0d issues exp=4", nissue);
    end
    s_awvalid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (s_awready !== 4'b0 || m_awvalid !== 1'b0 || busy !== 1'b1 || m_wvalid !== 1'b1 || m_wid !== 4'd0) begin
        errors++;
        $display("FAIL full_block got awr=%b awv=%b busy=%b wv=%b wid=%0d exp 0000/0/1/1/0",
                 s_awready, m_awvalid, busy, m_wvalid, m_wid);
      end
      @(negedge clk);
    end
    m_wready = 1'b1;
    #1;
    checks++;
    if (s_wready !== 4'b0001 || s_awready !== 4'b0 || m_wlast !== 1'b1) begin
      errors++;
      $display("FAIL full_pop got wr=%b awr=%b wlast=%b exp 0001/0000/1", s_wready, s_awready, m_wlast);
    end
    @(negedge clk);
    m_wready = 1'b0;
    #1;
    checks++;
    if (s_awready !== 4'b0001 || m_wid !== 4'd1) begin
      errors++;
      $display("FAIL full_regrant got awr=%b wid=%0d exp 0001/1", s_awready, m_wid);
    end
  endtask

  task automatic test_bresp();
    logic [1:0] resp;
    logic [3:0] exp_bv;
    logic       exp_rdy, exp_err;
    int         bid;
    do_reset();
    resp = 2'($urandom);
    m_bvalid = 1'b1; m_bid = 4'd2; m_bresp = resp; s_bready = 4'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (s_bvalid !== 4'b0100 || s_bresp[5:4] !== resp || m_bready !== 1'b0 || bid_err !== 1'b0) begin
        errors++;
        $display("FAIL b_hold got bv=%b resp=%b rdy=%b err=%b exp 0100/%b/0/0",
                 s_bvalid, s_bresp[5:4], m_bready, bid_err, resp);
      end
      @(negedge clk);
    end
    s_bready = 4'b0100;
    #1;
    checks++;
    if (s_bvalid !== 4'b0100 || m_bready !== 1'b1) begin
      errors++;
      $display("FAIL b_accept got bv=%b rdy=%b exp 0100/1", s_bvalid, m_bready);
    end
    @(negedge clk);
    m_bid = 4'd7; s_bready = 4'b0;
    #1;
    checks++;
    if (s_bvalid !== 4'b0 || m_bready !== 1'b1 || bid_err !== 1'b1) begin
      errors++;
      $display("FAIL b_bad_id got bv=%b rdy=%b err=%b exp 0000/1/1", s_bvalid, m_bready, bid_err);
    end
    @(negedge clk);
    m_bvalid = 1'b0;
    #1;
    checks++;
    if (bid_err !== 1'b0 || s_bvalid !== 4'b0) begin
      errors++;
      $display("FAIL b_err_pulse got err=%b bv=%b exp 0/0000", bid_err, s_bvalid);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bid = $urandom_range(0, 15);
      m_bid = 4'(bid); m_bvalid = 1'($urandom); m_bresp = 2'($urandom); s_bready = 4'($urandom);
      if (bid < 4) begin
        exp_bv  = m_bvalid ? 4'(1 << bid) : 4'b0;
        exp_rdy = s_bready[bid];
        exp_err = 1'b0;
      end else begin
        exp_bv  = 4'b0;
        exp_rdy = 1'b1;
        exp_err = m_bvalid;
      end
      #1;
      checks++;
      if (s_bvalid !== exp_bv || m_bready !== exp_rdy || bid_err !== exp_err ||
          (bid < 4 && s_bresp[bid*2 +: 2] !== m_bresp)) begin
        errors++;
        $display("FAIL b_random id=%0d got bv=%b rdy=%b err=%b exp bv=%b rdy=%b err=%b",
                 bid, s_bvalid, m_bready, bid_err, exp_bv, exp_rdy, exp_err);
      end
    end
    m_bvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nissue = 0, cyc = 0;
    logic [3:0] clr = '0;
    do_reset();
    set_fields(1, 2); set_fields(2, 1); set_fields(3, 0);
    s_wvalid = 4'hF; s_wlast = 4'h0; m_wready = 1'b0;
    s_awvalid = 4'b0110; m_awready = 1'b1;
    while (nissue < 2 && cyc < 40) begin
      #1;
      if (s_awready !== 4'b0) clr = s_awready;
      if (m_awvalid && m_awready) nissue++;
      @(negedge clk);
      s_awvalid = s_awvalid & ~clr;
      clr = '0;
      cyc++;
    end
    m_awready = 1'b0;
    s_awvalid = 4'b1000;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (nissue != 2 || m_awvalid !== 1'b1 || busy !== 1'b1 || m_wvalid !== 1'b1 || m_wid !== 4'd1) begin
      errors++;
      $display("FAIL mid_setup got issues=%0d awv=%b busy=%b wv=%b wid=%0d exp 2/1/1/1/1",
               nissue, m_awvalid, busy, m_wvalid, m_wid);
    end
    #2;
    rstnn = 1'b0;
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || busy !== 1'b0 || m_wvalid !== 1'b0 || s_wready !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset got awv=%b busy=%b wv=%b wr=%b exp 0/0/0/0000",
               m_awvalid, busy, m_wvalid, s_wready);
    end
    @(negedge clk);
    s_awvalid = 4'b1010;
    m_awready = 1'b1;
    rstnn = 1'b1;
    #1;
    checks++;
    if (s_awready !== 4'b0010) begin
      errors++;
      $display("FAIL mid_first_grant got=%b exp=0010", s_awready);
    end
    @(negedge clk);
    s_awvalid = 4'b1000;
    #1;
    checks++;
    if (m_awvalid !== 1'b1 || m_awid !== 4'd1 || m_awaddr !== ch_addr[1]) begin
      errors++;
      $display("FAIL mid_issue got awv=%b id=%0d addr=%h exp 1/1/%h", m_awvalid, m_awid, m_awaddr, ch_addr[1]);
    end
  endtask

  initial begin
    rstnn = 1'b0;
    test_reset();
    test_priority();
    test_round_robin();
    test_w_order();
    test_fifo_full();
    test_bresp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
